// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        RUN,
        FIX
    } mdu_state_t;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the EX-stage controller and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             lo_zero;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, hi, lo, lo_zero
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, hi, lo, lo_zero
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the datapath: shift-add multiply step or restoring-divide step.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
        w_ge     = (w_rem_sh >= {1'b0, i_opnd});
        w_sub    = w_rem_sh[WIDTH-1:0] - i_opnd;
        if (i_is_div) begin
            if (w_ge) begin
                o_acc = {w_sub, i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// state | meaning: IDLE wait for start | PREP take magnitudes, load count | RUN one bit per cycle | FIX sign-correct, write HI/LO
module alu_muldiv
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    alu_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t         r_state;
    mdu_state_t         w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept_md;
    logic               w_accept_mt;
    logic               w_write;
    logic               w_is_div;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    always_comb begin
        w_next      = r_state;
        w_accept_md = 1'b0;
        w_accept_mt = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (op_is_muldiv(bus.op)) begin
                        w_accept_md = 1'b1;
                        w_next      = PREP;
                    end else if ((bus.op == MTHI) || (bus.op == MTLO)) begin
                        w_accept_mt = 1'b1;
                    end
                end
            end
            PREP:    w_next = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_next  = IDLE;
                w_write = !bus.abort;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_is_div = op_is_div(r_op);
        w_sa     = op_is_signed(r_op) & r_a[WIDTH-1];
        w_sb     = op_is_signed(r_op) & r_b[WIDTH-1];
        w_abs_a  = w_sa ? -r_a : r_a;
        w_abs_b  = w_sb ? -r_b : r_b;
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_q      = r_acc[WIDTH-1:0];
        w_r      = r_acc[2*WIDTH-1:WIDTH];
        if (w_is_div) begin
            // a zero divisor leaves remainder = |a|; re-signing it by the dividend recovers a
            w_fix_lo = (r_opnd == '0) ? '1 : (r_neg_q ? -w_q : w_q);
            w_fix_hi = r_neg_r ? -w_r : w_r;
        end else begin
            {w_fix_hi, w_fix_lo} = w_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_write;
            if (w_accept_md) begin
                r_op <= bus.op;
                r_a  <= bus.a;
                r_b  <= bus.b;
            end
            if (w_accept_mt) begin
                if (bus.op == MTHI) begin
                    r_hi <= bus.a;
                end else begin
                    r_lo <= bus.a;
                end
            end
            if (r_state == PREP) begin
                r_cnt   <= CW'(WIDTH);
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                if (w_is_div) begin
                    r_opnd <= w_abs_b;
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                end else begin
                    r_opnd <= w_abs_a;
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                end
            end
            if (r_state == RUN) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_write) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.lo_zero = (r_lo == '0);
endmodule
